// File: rtl/sprite_anim_ctrl.sv
// Sprite animation controller: frame timer, STATIC/WALK/JUMP sequencing and a 3-stage pixel fetch pipeline.
// Optional macro TRANSPARENT_KEY_EN: pixels equal to KEY_COLOR become transparent (pix_hit=0, pix_out=0).
//
// state  | meaning
// STATIC | idle loop over N_FRAMES frames
// WALK   | walk loop over N_FRAMES frames
// JUMP   | jump frames 0..N_JUMP-1, holds on the last one
module sprite_anim_ctrl #(
  parameter int SPR_W    = 47,
  parameter int SPR_H    = 41,
  parameter int N_FRAMES = 4,
  parameter int N_JUMP   = 2,
  parameter int DIV      = 6000000,
  parameter int PIX_W    = 12,
  parameter int AW       = 16,
  parameter logic [PIX_W-1:0] KEY_COLOR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       char_state,
  input  logic             px_valid,
  input  logic [7:0]       px_x,
  input  logic [7:0]       px_y,
  output logic [AW-1:0]    rom_addr,
  input  logic [PIX_W-1:0] rom_data,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_valid,
  output logic             pix_hit,
  output logic [2:0]       frame_idx,
  output logic [1:0]       anim_state
);

  localparam logic [1:0] ST_STATIC = 2'd0;
  localparam logic [1:0] ST_WALK   = 2'd1;
  localparam logic [1:0] ST_JUMP   = 2'd2;

  localparam int     FR   = SPR_W * SPR_H;
  localparam longint SPAN = longint'(2 * N_FRAMES + N_JUMP) * longint'(SPR_W) * longint'(SPR_H);
  localparam int     TW   = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (SPAN > (longint'(1) << AW) || N_FRAMES > 8 || N_JUMP > 8 || N_FRAMES < 1 || N_JUMP < 1 || DIV < 1) begin : g_param_chk
      $error("sprite_anim_ctrl: illegal parameter set (ROM span exceeds 2^AW or frame counts out of range)");
    end
  endgenerate

  logic [1:0]      state_q, state_d, nxt_state;
  logic [2:0]      frame_q, frame_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            step;

  logic [AW-1:0]   rom_addr_q, addr_d, off, base, row, col;
  logic            in_range;
  logic            v1_q, inr1_q, v2_q, inr2_q;
  logic            pix_valid_q, pix_hit_q, hit_d;
  logic [PIX_W-1:0] pix_out_q;

  assign step = (timer_q == TW'(DIV - 1));

  always_comb begin
    nxt_state = ST_STATIC;
    case (char_state[1:0])
      2'b01:   nxt_state = ST_WALK;
      2'b10:   nxt_state = ST_JUMP;
      default: nxt_state = ST_STATIC;
    endcase
    state_d = state_q;
    frame_d = frame_q;
    timer_d = timer_q;
    // a state change wins over a coincident step
    if (nxt_state != state_q) begin
      state_d = nxt_state;
      frame_d = '0;
      timer_d = '0;
    end else begin
      timer_d = step ? '0 : timer_q + TW'(1);
      if (step) begin
        if (state_q == ST_JUMP) begin
          if (frame_q < 3'(N_JUMP - 1)) frame_d = frame_q + 3'd1;
        end else begin
          frame_d = (frame_q == 3'(N_FRAMES - 1)) ? 3'd0 : frame_q + 3'd1;
        end
      end
    end
  end

  always_comb begin
    off = '0;
    case (state_q)
      ST_WALK: off = AW'(N_FRAMES);
      ST_JUMP: off = AW'(2 * N_FRAMES);
      default: off = '0;
    endcase
    base     = (off + AW'(frame_q)) * AW'(FR);
    row      = AW'(px_y) * AW'(SPR_W);
    col      = char_state[2] ? (AW'(SPR_W - 1) - AW'(px_x)) : AW'(px_x);
    in_range = (32'(px_x) < 32'(SPR_W)) && (32'(px_y) < 32'(SPR_H));
    addr_d   = in_range ? (base + row + col) : '0;
  end

`ifdef TRANSPARENT_KEY_EN
  assign hit_d = v2_q & inr2_q & (rom_data != KEY_COLOR);
`else
  assign hit_d = v2_q & inr2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_STATIC;
      frame_q     <= '0;
      timer_q     <= '0;
      rom_addr_q  <= '0;
      v1_q        <= 1'b0;
      inr1_q      <= 1'b0;
      v2_q        <= 1'b0;
      inr2_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_hit_q   <= 1'b0;
      pix_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      timer_q     <= timer_d;
      if (px_valid) rom_addr_q <= addr_d;
      v1_q        <= px_valid;
      inr1_q      <= px_valid & in_range;
      v2_q        <= v1_q;
      inr2_q      <= inr1_q;
      pix_valid_q <= v2_q;
      pix_hit_q   <= hit_d;
      pix_out_q   <= hit_d ? rom_data : '0;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign pix_out    = pix_out_q;
  assign pix_valid  = pix_valid_q;
  assign pix_hit    = pix_hit_q;
  assign frame_idx  = frame_q;
  assign anim_state = state_q;

endmodule
